// File: rtl/rx_bit_timer.sv
// rx_bit_timer: USB RX bit-period timer; aligns to a D+ edge, then strobes the shift register once per bit.
// Optional RX_TIMER_RESYNC_EN: a d_edge while running re-centres the sample point.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       aligned
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE = 2'd0, ALIGN = 2'd1, RUN = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_PHASE);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  logic [1:0] state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic run, resync;

  assign run = state_q == RUN;
  assign shift_enable = run && enable_timer && clk_cnt_q == SAMPLE_CNT;
  assign byte_received = shift_enable && bit_count_q == LAST_BIT;
  assign bit_count = bit_count_q;
  assign aligned = run;

`ifdef RX_TIMER_RESYNC_EN
  assign resync = d_edge;
`else
  assign resync = 1'b0;
`endif

  // Dropping enable_timer wins over everything, including a coincident d_edge.
  always_comb begin
    state_d = !enable_timer ? IDLE :
              state_q == IDLE ? ALIGN :
              state_q == ALIGN ? (d_edge ? RUN : ALIGN) :
              state_q == RUN ? RUN : IDLE;
    clk_cnt_d = (!run || !enable_timer || resync || clk_cnt_q == LAST_CNT) ? '0 : clk_cnt_q + 1'b1;
    bit_count_d = (!run || !enable_timer) ? '0 :
                  !shift_enable ? bit_count_q :
                  bit_count_q == LAST_BIT ? '0 : bit_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clk_cnt_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_count_q <= bit_count_d;
    end
  end
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: randomized and directed bench for rx_bit_timer against a phase/strobe-count model.
module tb_rx_bit_timer;
  localparam int CPB = 8, SP = 3, BPB = 8;
  logic clk = 1'b0, rst, enable_timer, d_edge;
  logic shift_enable, byte_received, aligned;
  logic [3:0] bit_count;
  int checks = 0, errors = 0;
  int m_mode = 0, m_t0 = 0, m_strobes = 0, m_n = 0, phase;
  logic exp_se = 1'b0, exp_br = 1'b0, exp_al = 1'b0;
  logic [3:0] exp_bc = 4'd0;

  rx_bit_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP), .BITS_PER_BYTE(BPB)) dut (
    .clk(clk), .rst(rst), .enable_timer(enable_timer), .d_edge(d_edge),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .bit_count(bit_count), .aligned(aligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: mode 0 idle, 1 waiting for alignment edge, 2 running; phase = cycles since last alignment mod CPB.
  task automatic set_in(input logic en, input logic d);
    @(posedge clk);
    if (rst || !enable_timer) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (d_edge) begin m_mode = 2; m_t0 = m_n + 1; m_strobes = 0; end
    end else begin
      if (exp_se) m_strobes++;
`ifdef RX_TIMER_RESYNC_EN
      if (d_edge) m_t0 = m_n + 1;
`endif
    end
    m_n++;
    @(negedge clk);
    enable_timer = en;
    d_edge = d;
    #1;
    phase = (m_n - m_t0) % CPB;
    exp_al = m_mode == 2;
    exp_se = exp_al && en && phase == SP;
    exp_bc = exp_al ? 4'(m_strobes % BPB) : 4'd0;
    exp_br = exp_se && (m_strobes % BPB) == BPB - 1;
  endtask

  task automatic realign();
    set_in(1'b0, 1'b0);
    set_in(1'b1, 1'b0);
    set_in(1'b1, 1'b1);
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b0);
      if (shift_enable === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL wait_strobe: no shift_enable within 20 cycles, got %b required 1", shift_enable);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (shift_enable !== 1'b0 || byte_received !== 1'b0 || bit_count !== 4'd0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: se/br/bc/al got %b/%b/%0d/%b required 0/0/0/0", shift_enable, byte_received, bit_count, aligned);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_align();
    int first = -1, second = -1;
    set_in(1'b1, 1'b1);
    set_in(1'b1, 1'b0);
    checks++;
    if (aligned !== 1'b0) begin errors++; $display("FAIL align_idle_edge: aligned got %b required 0", aligned); end
    set_in(1'b1, 1'b0);
    set_in(1'b1, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      set_in(1'b1, 1'b0);
      checks++;
      if (shift_enable !== exp_se || byte_received !== exp_br || bit_count !== exp_bc || aligned !== exp_al) begin
        errors++;
        $display("FAIL align_model cyc %0d: se/br/bc/al got %b/%b/%0d/%b required %b/%b/%0d/%b", m_n, shift_enable, byte_received, bit_count, aligned, exp_se, exp_br, exp_bc, exp_al);
      end
      if (shift_enable === 1'b1) begin if (first < 0) first = i; else if (second < 0) second = i; end
    end
    checks++;
    if (first != 4 || second != 12) begin
      errors++;
      $display("FAIL align_timing: strobes at %0d,%0d required 4,12", first, second);
    end
  endtask

  task automatic test_byte();
    int k = 0;
    realign();
    for (int i = 0; i < 100 && k < 9; i++) begin
      set_in(1'b1, 1'b0);
      checks++;
      if (shift_enable !== exp_se || byte_received !== exp_br || bit_count !== exp_bc || aligned !== exp_al) begin
        errors++;
        $display("FAIL byte_model cyc %0d: se/br/bc/al got %b/%b/%0d/%b required %b/%b/%0d/%b", m_n, shift_enable, byte_received, bit_count, aligned, exp_se, exp_br, exp_bc, exp_al);
      end
      if (shift_enable === 1'b1) begin
        k++;
        checks++;
        if (bit_count !== 4'((k - 1) % 8) || byte_received !== (k == 8)) begin
          errors++;
          $display("FAIL byte_strobe %0d: bc/br got %0d/%b required %0d/%b", k, bit_count, byte_received, (k - 1) % 8, k == 8);
        end
      end
    end
    set_in(1'b1, 1'b0);
    checks++;
    if (bit_count !== 4'd1 || k != 9) begin
      errors++;
      $display("FAIL byte_ninth: bit_count got %0d strobes %0d required 1 and 9", bit_count, k);
    end
  endtask

  task automatic test_reset_midbyte();
    realign();
    for (int i = 0; i < 80 && bit_count !== 4'd5; i++) set_in(1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (shift_enable !== 1'b0 || byte_received !== 1'b0 || bit_count !== 4'd0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: se/br/bc/al got %b/%b/%0d/%b required 0/0/0/0", shift_enable, byte_received, bit_count, aligned);
    end
    set_in(1'b1, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 1'b0);
      checks++;
      if (shift_enable !== 1'b0 || byte_received !== 1'b0 || aligned !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: se/br/al got %b/%b/%b required 0/0/0", m_n, shift_enable, byte_received, aligned);
      end
    end
    set_in(1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) set_in(1'b1, 1'b0);
    checks++;
    if (shift_enable !== 1'b1 || bit_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_realign: se/bc got %b/%0d required 1/0", shift_enable, bit_count);
    end
  endtask

  task automatic test_resync();
    int first = -1, second = -1;
    int want = 6;
`ifdef RX_TIMER_RESYNC_EN
    want = 4;
`endif
    realign();
    wait_strobe();
    set_in(1'b1, 1'b0);
    set_in(1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      set_in(1'b1, 1'b0);
      if (shift_enable === 1'b1) begin if (first < 0) first = i; else if (second < 0) second = i; end
    end
    checks++;
    if (first != want || second != want + 8) begin
      errors++;
      $display("FAIL resync_spacing: strobes at %0d,%0d required %0d,%0d", first, second, want, want + 8);
    end
    wait_strobe();
    repeat (7) set_in(1'b1, 1'b0);
    set_in(1'b1, 1'b1);
    checks++;
    if (shift_enable !== 1'b1) begin errors++; $display("FAIL resync_on_sample: shift_enable got %b required 1", shift_enable); end
  endtask

  task automatic test_abort();
    realign();
    wait_strobe();
    repeat (7) set_in(1'b1, 1'b0);
    set_in(1'b0, 1'b1);
    checks++;
    if (shift_enable !== 1'b0 || byte_received !== 1'b0) begin
      errors++;
      $display("FAIL abort_gate: se/br got %b/%b required 0/0", shift_enable, byte_received);
    end
    set_in(1'b1, 1'b0);
    checks++;
    if (aligned !== 1'b0 || bit_count !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle: al/bc got %b/%0d required 0/0", aligned, bit_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      set_in(1'($urandom_range(0, 29) != 0), 1'($urandom_range(0, 4) == 0));
      checks++;
      if (shift_enable !== exp_se || byte_received !== exp_br || bit_count !== exp_bc || aligned !== exp_al) begin
        errors++;
        $display("FAIL random_model cyc %0d: se/br/bc/al got %b/%b/%0d/%b required %b/%b/%0d/%b", m_n, shift_enable, byte_received, bit_count, aligned, exp_se, exp_br, exp_bc, exp_al);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    enable_timer = 1'b0;
    d_edge = 1'b0;
    test_reset();
    test_align();
    test_byte();
    test_reset_midbyte();
    test_resync();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
